// File: rtl/hwr_lock_pkg.sv
// -----------------------------------------------------------------------------
// hwr_lock_pkg
// Shared constants and types for the hardware lock manager: command/ACK codes,
// command-word field positions, default sizing and the lock unit's source ID.
// -----------------------------------------------------------------------------
package hwr_lock_pkg;

    // Default sizing
    localparam int MAX_ACCS     = 16;
    localparam int ACC_BITS     = $clog2(MAX_ACCS);
    localparam int LOCK_ID_BITS = 8;

    // Command word fields
    localparam int CMD_TYPE_L = 0;
    localparam int CMD_TYPE_H = 7;
    localparam int LOCK_ID_L  = 8;
    localparam int LOCK_ID_H  = LOCK_ID_L + LOCK_ID_BITS - 1;

    // Command and ACK codes
    localparam logic [7:0] CMD_LOCK_CODE   = 8'h04;
    localparam logic [7:0] CMD_UNLOCK_CODE = 8'h06;
    localparam logic [7:0] ACK_OK_CODE     = 8'h01;
    localparam logic [7:0] ACK_REJECT_CODE = 8'h00;

    // Source ID stamped on every ACK
    localparam logic [4:0] HWR_LOCK_ID = 5'h15;

    typedef logic [CMD_TYPE_H:CMD_TYPE_L] cmd_t;

endpackage

// File: rtl/hwr_lock_if.sv
// -----------------------------------------------------------------------------
// hwr_lock_if
// Command (inStream) and ACK (outStream) AXI-Stream style channels.
//   slave  : the lock unit (consumes commands, produces ACKs)
//   master : the accelerator side (produces commands, consumes ACKs)
// -----------------------------------------------------------------------------
interface hwr_lock_if #(
    parameter int ACC_BITS = hwr_lock_pkg::ACC_BITS
);
    // Command channel
    logic [63:0]         inStream_tdata;
    logic                inStream_tvalid;
    logic                inStream_tready;
    logic [ACC_BITS-1:0] inStream_tid;
    logic                inStream_tlast;

    // ACK channel
    logic [63:0]         outStream_tdata;
    logic                outStream_tvalid;
    logic                outStream_tready;
    logic [ACC_BITS-1:0] outStream_tdest;
    logic [4:0]          outStream_tid;

    modport slave (
        input  inStream_tdata, inStream_tvalid, inStream_tid, inStream_tlast,
        output inStream_tready,
        output outStream_tdata, outStream_tvalid, outStream_tdest, outStream_tid,
        input  outStream_tready
    );

    modport master (
        output inStream_tdata, inStream_tvalid, inStream_tid, inStream_tlast,
        input  inStream_tready,
        input  outStream_tdata, outStream_tvalid, outStream_tdest, outStream_tid,
        output outStream_tready
    );

endinterface

// File: rtl/hwr_lock_owner_mem.sv
// -----------------------------------------------------------------------------
// hwr_lock_owner_mem
// Owner table: one entry per lock holding the accelerator ID that owns it.
// One write port, one synchronous read port.
//   clk      : clock
//   wr_en    : write enable
//   wr_addr  : lock ID to write
//   wr_data  : owner accelerator ID
//   rd_en    : read enable (rd_data holds when low)
//   rd_addr  : lock ID to read
//   rd_data  : owner of rd_addr, valid the cycle after rd_en
// -----------------------------------------------------------------------------
module hwr_lock_owner_mem
    import hwr_lock_pkg::*;
#(
    parameter int ADDR_BITS = LOCK_ID_BITS,
    parameter int DATA_BITS = ACC_BITS
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [DATA_BITS-1:0] rd_data
);

    logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

    // NOTE: storage has no reset so it maps onto RAM; an entry is only read
    // while its busy bit (which is reset) says the owner field is meaningful.
    // NOTE: non-blocking assignments for all clocked state, so every flop
    // samples values from before the edge regardless of statement order.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/hwr_lock.sv
// -----------------------------------------------------------------------------
// hwr_lock
// Hardware lock manager. Accelerators send single-beat lock/unlock commands
// (cmd in tdata[7:0], lock ID in tdata[15:8]); a lock request is answered
// with an OK/REJECT ACK routed back to the requester, unlocks are silent.
// Multi-beat packets are drained and ignored. One command in flight.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : command/ACK channels (hwr_lock_if.slave)
// -----------------------------------------------------------------------------
module hwr_lock
    import hwr_lock_pkg::*;
#(
    parameter int MAX_ACCS     = hwr_lock_pkg::MAX_ACCS,
    parameter int LOCK_ID_BITS = hwr_lock_pkg::LOCK_ID_BITS
) (
    input  logic      clk,
    input  logic      rst,
    hwr_lock_if.slave bus
);

    localparam int ACC_BITS  = $clog2(MAX_ACCS);
    localparam int NUM_LOCKS = 2**LOCK_ID_BITS;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]              state;
    cmd_t                    cmd_q;
    logic [LOCK_ID_BITS-1:0] id_q;
    logic [ACC_BITS-1:0]     tid_q;
    logic [NUM_LOCKS-1:0]    busy;
    logic [ACC_BITS-1:0]     owner_rd;

    logic [63:0]             ack_word;
    logic [63:0]             out_tdata;
    logic                    out_tvalid;
    logic [ACC_BITS-1:0]     out_tdest;

    cmd_t                    cmd_in;
    logic [LOCK_ID_BITS-1:0] id_in;
    logic                    in_hs;
    logic                    owner_rd_en;
    logic                    lock_grant;
    logic                    unlock_ok;
    logic                    unused_tdata_bits;

    assign cmd_in = bus.inStream_tdata[CMD_TYPE_H:CMD_TYPE_L];
    assign id_in  = bus.inStream_tdata[LOCK_ID_L +: LOCK_ID_BITS];
    assign unused_tdata_bits = ^bus.inStream_tdata[63:LOCK_ID_L+LOCK_ID_BITS];

    // tready is forced low during reset, not just by the reset state.
    assign bus.inStream_tready = !rst && (state == S_IDLE || state == S_DRAIN);
    assign in_hs               = bus.inStream_tvalid && bus.inStream_tready;

    // The owner lookup starts with the incoming lock ID while idle, so the
    // entry is ready when the captured command is evaluated in CHECK.
    assign owner_rd_en = (state == S_IDLE);

    assign lock_grant = (state == S_CHECK) && (cmd_q == CMD_LOCK_CODE) && !busy[id_q];
    assign unlock_ok  = (state == S_CHECK) && (cmd_q == CMD_UNLOCK_CODE) &&
                        busy[id_q] && (owner_rd == tid_q);

    hwr_lock_owner_mem #(
        .ADDR_BITS (LOCK_ID_BITS),
        .DATA_BITS (ACC_BITS)
    ) u_owner_mem (
        .clk     (clk),
        .wr_en   (lock_grant),
        .wr_addr (id_q),
        .wr_data (tid_q),
        .rd_en   (owner_rd_en),
        .rd_addr (id_in),
        .rd_data (owner_rd)
    );

    // NOTE: every bit gets a default first so no path leaves the word
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        ack_word = '0;
        ack_word[CMD_TYPE_H:CMD_TYPE_L]   = busy[id_q] ? ACK_REJECT_CODE : ACK_OK_CODE;
        ack_word[LOCK_ID_L +: LOCK_ID_BITS] = id_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cmd_q      <= '0;
            id_q       <= '0;
            tid_q      <= '0;
            busy       <= '0;
            out_tvalid <= 1'b0;
            out_tdata  <= '0;
            out_tdest  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_hs) begin
                        cmd_q <= cmd_in;
                        id_q  <= id_in;
                        tid_q <= bus.inStream_tid;
                        state <= bus.inStream_tlast ? S_CHECK : S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (in_hs && bus.inStream_tlast) begin
                        state <= S_IDLE;
                    end
                end
                S_CHECK: begin
                    state <= S_IDLE;
                    if (cmd_q == CMD_LOCK_CODE) begin
                        // Any lock request gets an answer; a held lock is
                        // rejected even when the requester already owns it.
                        if (lock_grant) begin
                            busy[id_q] <= 1'b1;
                        end
                        out_tvalid <= 1'b1;
                        out_tdata  <= ack_word;
                        out_tdest  <= tid_q;
                        state      <= S_RESP;
                    end else if (unlock_ok) begin
                        busy[id_q] <= 1'b0;
                    end
                end
                S_RESP: begin
                    if (bus.outStream_tready) begin
                        out_tvalid <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.outStream_tdata  = out_tdata;
    assign bus.outStream_tvalid = out_tvalid;
    assign bus.outStream_tdest  = out_tdest;
    assign bus.outStream_tid    = HWR_LOCK_ID;

endmodule

// File: tb/tb_hwr_lock.sv
// -----------------------------------------------------------------------------
// tb_hwr_lock
// Self-checking bench for hwr_lock: directed scenarios followed by randomized
// command traffic, all compared against a lock-table reference model.
// -----------------------------------------------------------------------------
module tb_hwr_lock;

    logic clk = 1'b0;
    logic rst = 1'b1;

    hwr_lock_if #(.ACC_BITS(4)) bus ();

    hwr_lock dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec     = 0;
    int n_err     = 0;
    int ack_count = 0;
    int in_beats  = 0;

    // Reference model: which locks are held and by whom.
    bit mbusy  [256];
    int mowner [256];

    always @(posedge clk) begin
        if (bus.outStream_tvalid && bus.outStream_tready) ack_count <= ack_count + 1;
        if (bus.inStream_tvalid && bus.inStream_tready)   in_beats  <= in_beats + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) mbusy[i] = 1'b0;
    endtask

    // Called at a negedge; returns once inStream_tready is high (bounded).
    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (bus.inStream_tready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("in_ready_timeout", 64'(bus.inStream_tready), 64'd1);
    endtask

    // Single-beat command with full ACK timing/content checks.
    task automatic do_cmd(input int tid, input logic [15:0] word, input int stall);
        bit          ok;
        logic [7:0]  cmd;
        logic [7:0]  id;
        logic [7:0]  code;
        bit          exp_ack;
        logic [63:0] exp_data;
        int          acks0;

        wait_ready(ok);
        if (!ok) return;

        cmd     = word[7:0];
        id      = word[15:8];
        code    = 8'h00;
        exp_ack = 1'b0;
        if (cmd == 8'h04) begin
            exp_ack = 1'b1;
            if (!mbusy[id]) begin
                code       = 8'h01;
                mbusy[id]  = 1'b1;
                mowner[id] = tid;
            end
        end else if (cmd == 8'h06) begin
            if (mbusy[id] && mowner[id] == tid) mbusy[id] = 1'b0;
        end
        exp_data = {48'h0, id, code};

        acks0                = ack_count;
        bus.inStream_tdata   = {48'h0, word};
        bus.inStream_tid     = 4'(tid);
        bus.inStream_tlast   = 1'b1;
        bus.inStream_tvalid  = 1'b1;
        @(negedge clk);
        bus.inStream_tvalid  = 1'b0;
        check("ack_early", 64'(bus.outStream_tvalid), 64'd0);
        @(negedge clk);
        check("ack_valid", 64'(bus.outStream_tvalid), 64'(exp_ack));
        if (exp_ack) begin
            check("ack_data", bus.outStream_tdata, exp_data);
            check("ack_dest", 64'(bus.outStream_tdest), 64'(tid));
            check("ack_src",  64'(bus.outStream_tid), 64'h15);
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                check("stall_valid", 64'(bus.outStream_tvalid), 64'd1);
                check("stall_data",  bus.outStream_tdata, exp_data);
                check("stall_inrdy", 64'(bus.inStream_tready), 64'd0);
            end
            bus.outStream_tready = 1'b1;
            @(negedge clk);
            bus.outStream_tready = 1'b0;
            check("ack_once", 64'(ack_count - acks0), 64'd1);
        end else begin
            check("no_ack", 64'(ack_count - acks0), 64'd0);
        end
    endtask

    // Multi-beat packet: every beat must be accepted and nothing happens.
    task automatic send_packet(input int tid, input logic [15:0] word, input int nbeats);
        bit ok;
        int beats0;
        int acks0;
        beats0 = in_beats;
        acks0  = ack_count;
        for (int b = 0; b < nbeats; b++) begin
            wait_ready(ok);
            if (!ok) return;
            bus.inStream_tdata  = (b == 0) ? {48'h0, word} : {$urandom, $urandom};
            bus.inStream_tid    = 4'(tid);
            bus.inStream_tlast  = (b == nbeats - 1);
            bus.inStream_tvalid = 1'b1;
            @(negedge clk);
            bus.inStream_tvalid = 1'b0;
        end
        repeat (2) @(negedge clk);
        check("pkt_beats", 64'(in_beats - beats0), 64'(nbeats));
        check("pkt_no_ack", 64'(ack_count - acks0), 64'd0);
        check("pkt_valid", 64'(bus.outStream_tvalid), 64'd0);
    endtask

    initial begin
        bit          ok;
        int          acks0;
        int          tid;
        logic [7:0]  id;
        logic [7:0]  cmd;
        logic [15:0] word;

        bus.inStream_tdata   = '0;
        bus.inStream_tvalid  = 1'b0;
        bus.inStream_tid     = '0;
        bus.inStream_tlast   = 1'b0;
        bus.outStream_tready = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_valid", 64'(bus.outStream_tvalid), 64'd0);
        check("rst_data",  bus.outStream_tdata, 64'd0);
        check("rst_dest",  64'(bus.outStream_tdest), 64'd0);
        check("rst_inrdy", 64'(bus.inStream_tready), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_inrdy", 64'(bus.inStream_tready), 64'd1);

        // Lock grant, contention, foreign unlock, owner unlock
        do_cmd(3, 16'h0504, 0);
        do_cmd(7, 16'h0504, 1);
        do_cmd(7, 16'h0506, 0);
        do_cmd(7, 16'h0504, 0);
        do_cmd(3, 16'h0504, 0);
        do_cmd(3, 16'h0506, 0);
        do_cmd(7, 16'h0504, 0);

        // Long downstream stall
        do_cmd(1, 16'h0004, 10);

        // Drained packets and an unknown command leave the table alone
        send_packet(1, 16'h0006, 3);
        do_cmd(2, 16'h0004, 0);
        send_packet(3, 16'h0A04, 3);
        do_cmd(4, 16'h0A04, 0);
        do_cmd(5, 16'h0909, 0);
        do_cmd(6, 16'h0904, 0);

        // Reset while an ACK is pending, lock 0xFF held
        do_cmd(2, 16'hFF04, 0);
        wait_ready(ok);
        if (ok) begin
            acks0               = ack_count;
            bus.inStream_tdata  = 64'h0000_0000_0000_FF04;
            bus.inStream_tid    = 4'd4;
            bus.inStream_tlast  = 1'b1;
            bus.inStream_tvalid = 1'b1;
            @(negedge clk);
            bus.inStream_tvalid = 1'b0;
            @(negedge clk);
            check("pre_rst_valid", 64'(bus.outStream_tvalid), 64'd1);
            rst = 1'b1;
            #1;
            check("arst_valid", 64'(bus.outStream_tvalid), 64'd0);
            check("arst_data",  bus.outStream_tdata, 64'd0);
            check("arst_dest",  64'(bus.outStream_tdest), 64'd0);
            check("arst_inrdy", 64'(bus.inStream_tready), 64'd0);
            @(negedge clk);
            check("arst_inrdy2", 64'(bus.inStream_tready), 64'd0);
            rst = 1'b0;
            model_reset();
            bus.outStream_tready = 1'b1;
            repeat (3) @(negedge clk);
            bus.outStream_tready = 1'b0;
            check("arst_no_ack", 64'(ack_count - acks0), 64'd0);
        end
        do_cmd(0, 16'hFF04, 0);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            tid = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 2));
            case ($urandom_range(0, 4))
                0:       id = 8'h00;
                1:       id = 8'hFF;
                2:       id = 8'h05;
                3:       id = 8'h09;
                default: id = 8'($urandom_range(0, 255));
            endcase
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: cmd = 8'h04;
                5, 6, 7, 8:    cmd = 8'h06;
                default:       cmd = ($urandom_range(0, 1) == 0) ? 8'h09 : 8'h00;
            endcase
            word = {id, cmd};
            if ($urandom_range(0, 7) == 0)
                send_packet(tid, word, int'($urandom_range(2, 4)));
            else
                do_cmd(tid, word, int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
